// File: rtl/seq_det_1101_pkg.sv
// Shared definitions for the 1101 serial pattern detector: state width and
// the state codes that are also visible on the debug/LED state output.
package seq_det_defs;

  localparam int STATE_W = 3;

  // Each state names the longest prefix of 1101 matched so far
  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S11  = 3'd2,
    S110 = 3'd3,
    DET  = 3'd4
  } state_t;

endpackage

// File: rtl/seq_det_1101_sat_counter.sv
// Saturating up-counter with a sticky overflow flag. The counter never wraps:
// an increment at full scale leaves the count at max and raises ovf instead.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  input  logic         sclr,
  output logic [W-1:0] cnt,
  output logic         ovf
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // Synchronous clear wins over a simultaneous increment; ovf stays set until cleared
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (sclr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (cnt == CNT_MAX) begin
        ovf <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_det_1101.sv
// Moore-style detector for the serial pattern 1101 (overlaps included) with a
// registered one-cycle det pulse and a saturating detection counter.
module seq_det_1101
  import seq_det_defs::*;
#(
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               din,
  input  logic               din_en,
  input  logic               cnt_clr,
  output logic               det,
  output logic [CNT_W-1:0]   det_cnt,
  output logic               ovf,
  output logic [STATE_W-1:0] state
);

  state_t cur_state;
  state_t next_state;
  logic   det_set;

  // Prefix tracker: advance only on enabled samples; unused codes fall back to IDLE
  always_comb begin
    next_state = cur_state;
    if (din_en) begin
      case (cur_state)
        IDLE:    next_state = din ? S1   : IDLE;
        S1:      next_state = din ? S11  : IDLE;
        S11:     next_state = din ? S11  : S110;
        S110:    next_state = din ? DET  : IDLE;
        DET:     next_state = din ? S11  : IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  assign det_set = din_en && (next_state == DET);

  // State register and the registered detection pulse
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cur_state <= IDLE;
      det       <= 1'b0;
    end else begin
      cur_state <= next_state;
      det       <= det_set;
    end
  end

  assign state = cur_state;

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .clr  (clr),
    .inc  (det_set),
    .sclr (cnt_clr),
    .cnt  (det_cnt),
    .ovf  (ovf)
  );

endmodule
